// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain_driver
// Initiator side of the ap_ctrl_chain handshake. Issues a commanded number
// of kernel transactions (ap_start/ap_ready), consumes results
// (ap_done/ap_continue), and tracks issued, completed and outstanding counts,
// stall cycles and a sticky protocol error.
// Optional feature: define RUN_CYCLES_EN to add the o_run_cycles output.
module ap_ctrl_chain_driver #(
   parameter  int CNT_W           = 32,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int OSD_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_cmd_valid,
   input  logic [CNT_W-1:0] i_cmd_count,
   output logic             o_cmd_ready,
   input  logic             i_sink_ready,
   output logic             o_ap_start,
   input  logic             i_ap_ready,
   input  logic             i_ap_done,
   output logic             o_ap_continue,
   output logic             o_busy,
   output logic             o_done_pulse,
   output logic [CNT_W-1:0] o_issued_cnt,
   output logic [CNT_W-1:0] o_completed_cnt,
   output logic [OSD_W-1:0] o_outstanding,
   output logic [CNT_W-1:0] o_stall_cycles,
`ifdef RUN_CYCLES_EN
   output logic [CNT_W-1:0] o_run_cycles,
`endif
   output logic             o_protocol_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [OSD_W-1:0] OSD_ONE = OSD_W'(1);
   localparam logic [OSD_W-1:0] OSD_CAP = OSD_W'(MAX_OUTSTANDING);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cmd_count;
   logic [CNT_W-1:0] r_to_issue;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_completed;
   logic [CNT_W-1:0] r_stall;
   logic [OSD_W-1:0] r_osd;
   logic             r_perr;

   logic             w_active;
   logic             w_start;
   logic             w_cont;
   logic             w_issue;
   logic             w_complete;
   logic             w_spurious;
   logic             w_accept;
   logic [CNT_W-1:0] w_completed_nxt;

   // Handshake decode; ap_start depends only on registered state so the
   // kernel never sees a combinational loop through ap_ready/ap_done.
   always_comb begin
      w_active        = (r_state == S_RUN) || (r_state == S_DRAIN);
      w_start         = (r_state == S_RUN) && (r_to_issue != '0) && (r_osd < OSD_CAP);
      w_cont          = i_sink_ready && w_active;
      w_issue         = w_start && i_ap_ready;
      // A completion with nothing in flight is only legal if the start is
      // accepted in the same cycle.
      w_complete      = i_ap_done && w_cont && ((r_osd != '0) || w_issue);
      w_spurious      = i_ap_done && w_active && (r_osd == '0) && !w_issue;
      w_accept        = (r_state == S_IDLE) && i_cmd_valid;
      w_completed_nxt = w_complete ? (r_completed + CNT_ONE) : r_completed;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_state_nxt   = r_state;
      o_cmd_ready   = 1'b0;
      o_busy        = 1'b1;
      o_done_pulse  = 1'b0;
      o_ap_start    = w_start;
      o_ap_continue = w_cont;
      case (r_state)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_cmd_valid) begin
               w_state_nxt = (i_cmd_count == '0) ? S_FINISH : S_RUN;
            end
         end
         S_RUN: begin
            if (w_issue && (r_to_issue == CNT_ONE)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_completed_nxt == r_cmd_count) begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            o_done_pulse = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Run bookkeeping: cleared on command accept, updated on handshakes.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cmd_count <= '0;
         r_to_issue  <= '0;
         r_issued    <= '0;
         r_completed <= '0;
         r_stall     <= '0;
         r_osd       <= '0;
         r_perr      <= 1'b0;
      end else if (w_accept) begin
         r_cmd_count <= i_cmd_count;
         r_to_issue  <= i_cmd_count;
         r_issued    <= '0;
         r_completed <= '0;
         r_stall     <= '0;
         r_osd       <= '0;
         r_perr      <= 1'b0;
      end else begin
         if (w_issue) begin
            r_to_issue <= r_to_issue - CNT_ONE;
            r_issued   <= r_issued + CNT_ONE;
         end
         r_completed <= w_completed_nxt;
         case ({w_issue, w_complete})
            2'b10:   r_osd <= r_osd + OSD_ONE;
            2'b01:   r_osd <= r_osd - OSD_ONE;
            default: r_osd <= r_osd;
         endcase
         if (w_start && !i_ap_ready && (r_stall != CNT_MAX)) begin
            r_stall <= r_stall + CNT_ONE;
         end
         if (w_spurious) begin
            r_perr <= 1'b1;
         end
      end
   end

`ifdef RUN_CYCLES_EN
   logic [CNT_W-1:0] r_run_cycles;

   // Cycles spent in RUN/DRAIN for the current command; holds after the run.
   always_ff @(posedge i_clock) begin
      if (i_reset || w_accept) begin
         r_run_cycles <= '0;
      end else if (w_active && (r_run_cycles != CNT_MAX)) begin
         r_run_cycles <= r_run_cycles + CNT_ONE;
      end
   end

   assign o_run_cycles = r_run_cycles;
`endif

   assign o_issued_cnt    = r_issued;
   assign o_completed_cnt = r_completed;
   assign o_outstanding   = r_osd;
   assign o_stall_cycles  = r_stall;
   assign o_protocol_err  = r_perr;

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Bench for ap_ctrl_chain_driver: a kernel model answers the handshake,
// a transaction-level reference predicts every output each cycle, and
// directed scenarios pin key results with hand-computed literals.
module tb_ap_ctrl_chain_driver;
   localparam int CW   = 32;
   localparam int MAXO = 4;
   localparam int OW   = $clog2(MAXO + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [CW-1:0] cmd_count = '0;
   logic          sink_ready = 1'b1;
   logic          ap_ready = 1'b0;
   logic          ap_done = 1'b0;
   logic          cmd_ready, ap_start, ap_continue, busy, done_pulse, perr;
   logic [CW-1:0] issued, completed, stall;
   logic [OW-1:0] osd;
`ifdef RUN_CYCLES_EN
   logic [CW-1:0] run_cycles;
`endif

   always #5 clk = ~clk;

   ap_ctrl_chain_driver #(.CNT_W(CW), .MAX_OUTSTANDING(MAXO)) dut (
      .i_clock(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd_count(cmd_count),
      .o_cmd_ready(cmd_ready), .i_sink_ready(sink_ready), .o_ap_start(ap_start),
      .i_ap_ready(ap_ready), .i_ap_done(ap_done), .o_ap_continue(ap_continue),
      .o_busy(busy), .o_done_pulse(done_pulse), .o_issued_cnt(issued),
      .o_completed_cnt(completed), .o_outstanding(osd), .o_stall_cycles(stall),
`ifdef RUN_CYCLES_EN
      .o_run_cycles(run_cycles),
`endif
      .o_protocol_err(perr)
   );

   int checks = 0;
   int errors = 0;

   // kernel model
   int q[$];
   int wcnt = 0;
   int rdy_dly = 0;
   int lat = 3;
   bit force_done = 1'b0;

   // reference: phase 0 idle, 1 issuing, 2 draining, 3 finishing
   int        m_phase = 0;
   bit        m_valid = 1'b0;
   bit        m_perr = 1'b0;
   bit [31:0] m_count, m_issued, m_completed, m_stall, m_rc;
   bit        simul_now = 1'b0;
   int        simul_hits = 0;

   // bookkeeping
   int cyc = 0;
   int acc_edge = 0;
   int done_edge = 0;
   int dp_cnt = 0;
   int max_osd = 0;
   bit got_done = 1'b0;
   bit start_seen = 1'b0;
   bit s_rst, s_valid, s_sink, s_ready, s_done, s_start, s_cont, s_force;
   bit [31:0] s_count;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   function automatic bit m_start_f();
      return (m_phase == 1) && (m_issued < m_count) && ((m_issued - m_completed) < MAXO);
   endfunction

   task automatic model_update();
      bit st, iss, cmp;
      bit [31:0] o;
      simul_now = 1'b0;
      if (s_rst) begin
         m_phase = 0; m_count = 0; m_issued = 0; m_completed = 0;
         m_stall = 0; m_rc = 0; m_perr = 1'b0; m_valid = 1'b1;
      end else begin
         case (m_phase)
            0: if (s_valid) begin
               m_count = s_count; m_issued = 0; m_completed = 0;
               m_stall = 0; m_rc = 0; m_perr = 1'b0;
               m_phase = (s_count == 0) ? 3 : 1;
            end
            1, 2: begin
               st  = m_start_f();
               iss = st && s_ready;
               o   = m_issued - m_completed;
               cmp = s_done && s_sink && (o > 0 || iss);
               if (s_done && o == 0 && !iss) m_perr = 1'b1;
               if (st && !s_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
               if (iss && cmp && o == 2) simul_now = 1'b1;
               m_issued    += 32'(iss);
               m_completed += 32'(cmp);
               if (m_rc != 32'hFFFF_FFFF) m_rc++;
               if (m_phase == 1 && m_issued == m_count) m_phase = 2;
               else if (m_phase == 2 && m_completed == m_count) m_phase = 3;
            end
            default: m_phase = 0;
         endcase
      end
   endtask

   // One clock: drive kernel inputs, compare all outputs, cross the edge,
   // then advance kernel model and reference.
   task automatic tick();
      ap_done  = force_done || (q.size() > 0 && q[0] <= cyc);
      ap_ready = (rdy_dly == 0) ? 1'b1 : (ap_start === 1'b1 && wcnt >= rdy_dly);
      #1;
      if (m_valid) begin
         chk("cmd_ready", cmd_ready, m_phase == 0);
         chk("busy", busy, m_phase != 0);
         chk("done_pulse", done_pulse, m_phase == 3);
         chk("ap_start", ap_start, m_start_f());
         chk("ap_continue", ap_continue, sink_ready && (m_phase == 1 || m_phase == 2));
         chk("issued_cnt", issued, m_issued);
         chk("completed_cnt", completed, m_completed);
         chk("outstanding", osd, m_issued - m_completed);
         chk("stall_cycles", stall, m_stall);
         chk("protocol_err", perr, m_perr);
`ifdef RUN_CYCLES_EN
         chk("run_cycles", run_cycles, m_rc);
`endif
         if (int'(osd) > max_osd) max_osd = int'(osd);
      end
      if (done_pulse === 1'b1) begin got_done = 1'b1; done_edge = cyc; dp_cnt++; end
      if (ap_start === 1'b1) start_seen = 1'b1;
      s_rst = rst; s_valid = cmd_valid; s_count = cmd_count; s_sink = sink_ready;
      s_ready = ap_ready; s_done = ap_done; s_start = (ap_start === 1'b1);
      s_cont = (ap_continue === 1'b1); s_force = force_done;
      @(posedge clk);
      cyc++;
      if (s_rst) begin
         q.delete(); wcnt = 0;
      end else begin
         if (s_start && s_ready) begin q.push_back(cyc + lat); wcnt = 0; end
         else if (s_start) wcnt++;
         if (s_done && s_cont && !s_force && q.size() > 0) void'(q.pop_front());
      end
      model_update();
      @(negedge clk);
      if (simul_now) begin
         simul_hits++;
         chk("simul_issue_complete_osd", osd, 2);
      end
   endtask

   task automatic send(input int n);
      cmd_valid = 1'b1; cmd_count = CW'(n);
      got_done = 1'b0; dp_cnt = 0; start_seen = 1'b0; max_osd = 0;
      tick();
      acc_edge = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && !got_done; i++) tick();
      chk("done_within_budget", got_done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_ap_start", ap_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_issued", issued, 0);

      // 1: five back-to-back, 3-cycle kernel, outstanding caps at 4
      rdy_dly = 0; lat = 3; sink_ready = 1'b1;
      send(5); run_until_done(60);
      chk("t1_issued", issued, 5);
      chk("t1_completed", completed, 5);
      chk("t1_stall", stall, 0);
      chk("t1_max_osd", max_osd, 4);
      chk("t1_done_latency", done_edge - acc_edge + 1, 11);
`ifdef RUN_CYCLES_EN
      chk("t1_run_cycles", run_cycles, 10);
`endif
      tick();
      chk("t1_done_pulses", dp_cnt, 1);

      // 2: ap_ready held low four cycles per start
      rdy_dly = 4; lat = 3;
      send(3); run_until_done(80);
      chk("t2_stall", stall, 12);
      chk("t2_completed", completed, 3);

      // 3: sink back-pressure while results are pending
      rdy_dly = 0; lat = 3; sink_ready = 1'b0;
      send(8);
      repeat (10) tick();
      chk("t3_continue_low", ap_continue, 0);
      chk("t3_completed_held", completed, 0);
      chk("t3_osd_cap", osd, 4);
      chk("t3_start_dropped", ap_start, 0);
      sink_ready = 1'b1;
      run_until_done(80);
      chk("t3_completed", completed, 8);
      chk("t3_issued", issued, 8);

      // 4: empty command
      send(0); run_until_done(5);
      chk("t4_done_latency", done_edge - acc_edge + 1, 1);
      chk("t4_no_start", start_seen, 0);
      chk("t4_issued", issued, 0);
      chk("t4_completed", completed, 0);

      // 5a: 1-cycle kernel yields issue+complete at outstanding 2
      rdy_dly = 0; lat = 1; simul_hits = 0;
      send(6); run_until_done(60);
      chk("t5_simul_seen", simul_hits > 0, 1);
      chk("t5_completed", completed, 6);

      // 5b: spurious ap_done with nothing in flight
      rdy_dly = 5; lat = 3;
      send(2); tick();
      force_done = 1'b1; tick(); force_done = 1'b0;
      chk("t5_perr_set", perr, 1);
      chk("t5_completed_unchanged", completed, 0);
      run_until_done(80);
      chk("t5_perr_sticky", perr, 1);
      chk("t5_completed_final", completed, 2);

      // 6: reset after two issues aborts the run
      rdy_dly = 0; lat = 3;
      send(5); tick(); tick();
      chk("t6_issued_before", issued, 2);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_cmd_ready", cmd_ready, 1);
      chk("t6_ap_start", ap_start, 0);
      chk("t6_busy", busy, 0);
      chk("t6_issued", issued, 0);
      chk("t6_osd", osd, 0);
      chk("t6_perr", perr, 0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
